// File: rtl/sd_decimator.sv
// Sinc1 (count-of-ones) decimator for a 1-bit sigma-delta bitstream over windows of 2^RES clocks.
// Optional two-window averaging is enabled by defining SD_DECIM_AVG2_EN.
module sd_decimator #(
    parameter int unsigned RES        = 8,
    parameter int unsigned SETTLE_WIN = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           conv,
    input  logic           sd_in,
    output logic [RES-1:0] dout,
    output logic           dout_valid,
    output logic           busy,
    output logic           ovr
);

    localparam int unsigned ACC_W  = RES + 1;
    localparam int unsigned SCNT_W = (SETTLE_WIN > 0) ? $clog2(SETTLE_WIN + 1) : 1;
    localparam logic [ACC_W-1:0]  FULL      = ACC_W'(1) << RES;
    localparam logic [RES-1:0]    WIN_LAST  = '1;
    localparam logic [RES-1:0]    DOUT_MAX  = '1;
    localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(SETTLE_WIN - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RUN    = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [ACC_W-1:0]  acc, acc_nxt;
    logic [RES-1:0]    wcnt, wcnt_nxt;
    logic [SCNT_W-1:0] scnt, scnt_nxt;
    logic [RES-1:0]    dout_nxt;
    logic              valid_nxt, ovr_nxt, busy_nxt;
    logic [ACC_W-1:0]  count;
    logic              win_end;

`ifdef SD_DECIM_AVG2_EN
    logic [ACC_W-1:0] c_prev, c_prev_nxt;
    logic             prev_vld, prev_vld_nxt;
    logic [ACC_W:0]   pair_sum;
    logic [ACC_W-1:0] pair_avg;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            acc        <= '0;
            wcnt       <= '0;
            scnt       <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            ovr        <= 1'b0;
            busy       <= 1'b0;
`ifdef SD_DECIM_AVG2_EN
            c_prev     <= '0;
            prev_vld   <= 1'b0;
`endif
        end else begin
            state      <= state_nxt;
            acc        <= acc_nxt;
            wcnt       <= wcnt_nxt;
            scnt       <= scnt_nxt;
            dout       <= dout_nxt;
            dout_valid <= valid_nxt;
            ovr        <= ovr_nxt;
            busy       <= busy_nxt;
`ifdef SD_DECIM_AVG2_EN
            c_prev     <= c_prev_nxt;
            prev_vld   <= prev_vld_nxt;
`endif
        end
    end

    // Next-state and datapath; conv low in SETTLE/RUN aborts the partial window.
    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        wcnt_nxt  = wcnt;
        scnt_nxt  = scnt;
        dout_nxt  = dout;
        valid_nxt = 1'b0;
        ovr_nxt   = ovr;
        count     = acc + ACC_W'(sd_in);
        win_end   = (wcnt == WIN_LAST);
`ifdef SD_DECIM_AVG2_EN
        c_prev_nxt   = c_prev;
        prev_vld_nxt = prev_vld;
        pair_sum     = {1'b0, c_prev} + {1'b0, count};
        pair_avg     = pair_sum[ACC_W:1];
`endif

        unique case (state)
            IDLE: begin
                if (conv) begin
                    state_nxt = (SETTLE_WIN == 0) ? RUN : SETTLE;
                    acc_nxt   = '0;
                    wcnt_nxt  = '0;
                    scnt_nxt  = '0;
                end
            end

            SETTLE, RUN: begin
                if (!conv) begin
                    state_nxt = IDLE;
                    acc_nxt   = '0;
                    wcnt_nxt  = '0;
                    scnt_nxt  = '0;
`ifdef SD_DECIM_AVG2_EN
                    c_prev_nxt   = '0;
                    prev_vld_nxt = 1'b0;
`endif
                end else begin
                    acc_nxt  = count;
                    wcnt_nxt = wcnt + RES'(1);
                    if (win_end) begin
                        acc_nxt = '0;
                        if (state == SETTLE) begin
                            if (scnt == SCNT_LAST) begin
                                state_nxt = RUN;
                                scnt_nxt  = '0;
                            end else begin
                                scnt_nxt = scnt + SCNT_W'(1);
                            end
                        end else begin
`ifdef SD_DECIM_AVG2_EN
                            // First RUN window only primes c_prev.
                            c_prev_nxt   = count;
                            prev_vld_nxt = 1'b1;
                            if (prev_vld) begin
                                dout_nxt  = pair_avg[RES] ? DOUT_MAX : pair_avg[RES-1:0];
                                ovr_nxt   = (c_prev == FULL) || (count == FULL);
                                valid_nxt = 1'b1;
                            end
`else
                            dout_nxt  = (count == FULL) ? DOUT_MAX : count[RES-1:0];
                            ovr_nxt   = (count == FULL);
                            valid_nxt = 1'b1;
`endif
                        end
                    end
                end
            end

            default: begin
                state_nxt = IDLE;
                acc_nxt   = '0;
                wcnt_nxt  = '0;
                scnt_nxt  = '0;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

endmodule

// File: tb/tb_sd_decimator.sv
// Self-checking bench for sd_decimator: vector table of bitstream patterns plus abort/reset sequences,
// with a queue of expected samples pushed as each full RUN window is driven.
module tb_sd_decimator;

    localparam int unsigned RES = 8;
    localparam int unsigned SW  = 1;
    localparam int          N   = 256;
`ifdef SD_DECIM_AVG2_EN
    localparam int          AVG = 1;
`else
    localparam int          AVG = 0;
`endif
    localparam int          LAT = (SW + 1 + AVG) * N;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           conv = 1'b0;
    logic           sd_in = 1'b0;
    logic [RES-1:0] dout;
    logic           dout_valid;
    logic           busy;
    logic           ovr;

    sd_decimator #(.RES(RES), .SETTLE_WIN(SW)) dut (
        .clk        (clk),
        .rst        (rst),
        .conv       (conv),
        .sd_in      (sd_in),
        .dout       (dout),
        .dout_valid (dout_valid),
        .busy       (busy),
        .ovr        (ovr)
    );

    always #5 clk = ~clk;

    typedef struct {
        int d;
        int o;
    } exp_t;

    typedef struct {
        int kind;   // 0 constant bit, 1 alternating 1/0, 2 first-order modulator
        int val;
        int exp_d;
        int exp_o;
    } vec_t;

    exp_t       sb_q[$];
    vec_t       tbl[8];
    int         checks = 0;
    int         errors = 0;
    int         exp_dout = 0, exp_ovr = 0;
    int         last_dout = 0, last_ovr = 0;
    bit         started = 1'b0;
    int         cyc = 0;
    int         valid_cnt = 0;
    int         gen_kind = 0, gen_val = 0, gen_j = 0;
    logic [7:0] mod_acc = 8'd0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // One clock: drive inputs, update the window timeline, then check outputs after the edge.
    task automatic tick(input logic c, input logic s, input logic r);
        exp_t e;
        bit   pushed;
        pushed = 1'b0;
        conv  = c;
        sd_in = s;
        rst   = r;
        if (r || !c) begin
            started = 1'b0;
            cyc     = 0;
        end else if (!started) begin
            started   = 1'b1;
            cyc       = 0;
            valid_cnt = 0;
        end else begin
            cyc++;
            if ((cyc % N) == 0 && (cyc / N) >= (SW + 1 + AVG)) begin
                e.d = exp_dout;
                e.o = exp_ovr;
                sb_q.push_back(e);
                pushed = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        if (r) begin
            last_dout = 0;
            last_ovr  = 0;
        end
        chk("busy", int'(busy), int'(!r && c));
        if (dout_valid) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid actual=1 required=0 dout=%0d (t=%0t)", dout, $time);
            end else begin
                e = sb_q.pop_front();
                chk("dout", int'(dout), e.d);
                chk("ovr", int'(ovr), e.o);
                if (valid_cnt == 0) chk("first_latency", cyc, LAT);
                valid_cnt++;
                last_dout = e.d;
                last_ovr  = e.o;
            end
        end else begin
            chk("dout_hold", int'(dout), last_dout);
            chk("ovr_hold", int'(ovr), last_ovr);
        end
        if (pushed) begin
            chk("valid_on_time", sb_q.size(), 0);
            sb_q.delete();
        end
    endtask

    function automatic logic gen_bit();
        logic [8:0] s9;
        logic       b;
        case (gen_kind)
            0:       b = (gen_val != 0);
            1:       b = ((gen_j % 2) == 0);
            default: begin
                s9      = {1'b0, mod_acc} + {1'b0, 8'(gen_val)};
                b       = s9[8];
                mod_acc = s9[7:0];
            end
        endcase
        gen_j++;
        return b;
    endfunction

    task automatic set_gen(input int kind, input int val, input int ed, input int eo);
        gen_kind = kind;
        gen_val  = val;
        gen_j    = -1;
        mod_acc  = 8'd0;
        exp_dout = ed;
        exp_ovr  = eo;
    endtask

    task automatic drive_on(input int n);
        for (int i = 0; i < n; i++) tick(1'b1, gen_bit(), 1'b0);
    endtask

    task automatic do_reset();
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
    endtask

`ifdef SD_DECIM_AVG2_EN
    task automatic two_windows(input int c0, input int c1, input int ed, input int eo);
        exp_dout = ed;
        exp_ovr  = eo;
        tick(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < SW * N; i++) tick(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < N; i++) tick(1'b1, logic'(i < c0), 1'b0);
        for (int i = 0; i < N; i++) tick(1'b1, logic'(i < c1), 1'b0);
        tick(1'b0, 1'b0, 1'b0);
    endtask
`endif

    initial begin
        tbl[0] = '{kind: 0, val: 1,    exp_d: 255, exp_o: 1};
        tbl[1] = '{kind: 0, val: 0,    exp_d: 0,   exp_o: 0};
        tbl[2] = '{kind: 1, val: 0,    exp_d: 128, exp_o: 0};
        tbl[3] = '{kind: 2, val: 'h40, exp_d: 64,  exp_o: 0};
        tbl[4] = '{kind: 2, val: 'h00, exp_d: 0,   exp_o: 0};
        tbl[5] = '{kind: 2, val: 'hC5, exp_d: 197, exp_o: 0};
        tbl[6] = '{kind: 2, val: 'hFF, exp_d: 255, exp_o: 0};
        tbl[7] = '{kind: 2, val: 'h01, exp_d: 1,   exp_o: 0};

        do_reset();
        chk("reset_valid", int'(dout_valid), 0);
        chk("reset_dout", int'(dout), 0);

        // Idle with conv low: nothing sampled, no pulses.
        for (int i = 0; i < 20; i++) tick(1'b0, 1'b1, 1'b0);

        foreach (tbl[i]) begin
            do_reset();
            set_gen(tbl[i].kind, tbl[i].val, tbl[i].exp_d, tbl[i].exp_o);
            drive_on(1 + LAT + 2 * N);
            tick(1'b0, 1'b0, 1'b0);
        end

        // Abort mid-RUN at window cycle 200, restart 10 cycles later with a different pattern.
        do_reset();
        set_gen(1, 0, 128, 0);
        drive_on(1 + LAT + 200);
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b1, 1'b0);
        chk("abort_hold_dout", int'(dout), 128);
        set_gen(0, 1, 255, 1);
        drive_on(1 + LAT);
        chk("restart_count", valid_cnt, 1);

        // conv dropped on the last edge of a RUN window: no pulse for that window.
        tick(1'b0, 1'b0, 1'b0);
        set_gen(1, 0, 128, 0);
        drive_on(1 + LAT + N - 1);
        tick(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, 1'b0);
        chk("window_end_abort_dout", int'(dout), 128);

        // Reset mid-RUN with conv held high; outputs clear, then conversion restarts.
        set_gen(0, 1, 255, 1);
        drive_on(1 + LAT + N + 50);
        tick(1'b1, 1'b1, 1'b1);
        chk("midrun_reset_dout", int'(dout), 0);
        chk("midrun_reset_ovr", int'(ovr), 0);
        chk("midrun_reset_valid", int'(dout_valid), 0);
        drive_on(1 + LAT);
        tick(1'b0, 1'b0, 1'b0);

`ifdef SD_DECIM_AVG2_EN
        do_reset();
        two_windows(100, 103, 101, 0);
        two_windows(256, 0, 128, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sd_decimator.md
Name: sd_decimator

Overview:
- Receive-side counterpart to the team's first-order sigma-delta DAC modulator.
- Takes the 1-bit bitstream (modulator output, or an external sigma-delta ADC front end) and reconstructs RES-bit samples with a sinc1 (count-of-ones) decimator over fixed windows of 2^RES clocks.
- Used in loopback verification of the modulator and as the digital back end of a sigma-delta ADC path.

Parameters:
- RES, 8: output resolution; window length N = 2^RES clocks.
- SETTLE_WIN, 1: number of whole windows discarded after conversion start (modulator start-up transient); 0 allowed.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- conv  in  1  conversion enable; same meaning as the modulator's conv.
- sd_in  in  1  bitstream, sampled on rising clk.
- dout  out  RES  decoded sample; holds its value between valid pulses.
- dout_valid  out  1  one-cycle pulse when dout updates.
- busy  out  1  high in SETTLE or RUN.
- ovr  out  1  high with the sample whose window count saturated; updates only with dout_valid.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high. All state updates on rising clk only.
- Reset values: dout=0, dout_valid=0, busy=0, ovr=0, state=IDLE, window counter wcnt=0, ones accumulator acc=0, settle counter=0.
- Reset has priority over conv. Reset mid-operation discards the partial window.
- Registers:
  - wcnt is RES bits and wraps naturally.
  - acc is RES+1 bits and holds 0..N.
  - scnt is wide enough for SETTLE_WIN.
- FSM IDLE:
  - busy=0, nothing is sampled, dout holds.
  - conv=1 at an edge moves to SETTLE, or to RUN if SETTLE_WIN=0, with wcnt=0 and acc=0.
  - The first sd_in sample is taken on the following edge.
- FSM SETTLE:
  - Each edge samples sd_in into acc and increments wcnt.
  - When wcnt==N-1, increment scnt and clear acc.
  - When scnt reaches SETTLE_WIN, move to RUN.
  - No dout_valid is produced in SETTLE.
- FSM RUN:
  - Each edge: acc <= acc + sd_in; wcnt <= wcnt+1.
  - On the edge where wcnt==N-1, the final count is c = acc + sd_in.
  - dout <= (c==N) ? N-1 : c[RES-1:0]; ovr <= (c==N); dout_valid <= 1 for exactly one cycle.
  - acc <= 0 on the same edge, so the next window starts seamlessly with no gap cycle.
- conv=0 at any edge in SETTLE or RUN:
  - Next state is IDLE; acc, wcnt and scnt are cleared.
  - No valid pulse is produced for a partial window, even if wcnt==N-1 on that edge.
  - dout and ovr hold.
- Latency: conv first seen high at edge k gives the first dout_valid high after edge k+(SETTLE_WIN+1)·N. Defaults: k+512. After that, one pulse every N cycles.
- Accuracy: for a first-order modulator input x, each RUN window yields x or x±1. With SETTLE_WIN≥1 and the modulator's conv driven identically, the result is exactly x.

Optional Feature:
- Macro SD_DECIM_AVG2_EN.
- Defined:
  - Output is the average of the last two window counts: dout = min((c_prev + c) >> 1, N-1). The sum is RES+2 bits wide; round down.
  - ovr = (c_prev==N) | (c==N).
  - The first RUN window only loads c_prev and emits no valid. First valid at edge k+(SETTLE_WIN+2)·N; later valids every N cycles.
  - c_prev clears on rst and on return to IDLE.
- Undefined: the plain sinc1 behaviour above. No extra registers.

Test Plan:
- RES=8, SETTLE_WIN=1, conv=1, sd_in constant 1 -> first dout_valid after edge k+512; dout=255, ovr=1.
- sd_in constant 0 -> dout=0x00, ovr=0; valid pulses spaced exactly 256 cycles apart.
- Alternating 1,0 starting with 1 -> dout=128 every window; dout_valid is one cycle wide.
- Loopback: dac modulator with dac_in=0x40, same clk, conv and reset -> every dout=64. Repeat for dac_in=0x00 -> 0 and 0xC5 -> 197.
- Drop conv at RUN window cycle 200, raise it again 10 cycles later -> no valid for the aborted window; dout holds its old value; next valid 512 cycles after conv is re-seen. Assert rst mid-RUN -> all outputs 0 next cycle.
- With SD_DECIM_AVG2_EN, windows of counts 100 then 103 -> first valid at edge k+768 with dout=101; windows of counts 256 then 0 -> dout=128, ovr=1.
